// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the accumulator CPU blocks: the instruction
// opcode set, the control FSM state encoding, the datapath mux selects and
// ALU operation codes. It also holds a helper that maps raw opcode fields onto
// the legal opcode set.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_WIDTH   = 11;
    localparam int OPCODE_WIDTH = 5;
    localparam int INSTR_WIDTH  = OPCODE_WIDTH + DATA_WIDTH;

    typedef enum logic [4:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111,
        OP_BEQ  = 5'b01000,
        OP_BNE  = 5'b01001,
        OP_BGT  = 5'b01010,
        OP_BGE  = 5'b01011,
        OP_BLT  = 5'b01100,
        OP_BLE  = 5'b01101,
        OP_JMP  = 5'b01110,
        OP_NOP  = 5'b01111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMWB,
        ST_HALT
    } state_e;

    // Accumulator source select.
    typedef enum logic [1:0] {
        SEL_A_MEM = 2'b00,
        SEL_A_IMM = 2'b01,
        SEL_A_ALU = 2'b10
    } sel_a_e;

    // ALU B source select.
    localparam logic SEL_B_MEM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    // ALU operation.
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // The upper half of the opcode space is unused; those encodings behave
    // exactly like HLT so a corrupted program stops instead of running wild.
    function automatic opcode_e decode_opcode(input logic [OPCODE_WIDTH-1:0] raw);
        if (raw[OPCODE_WIDTH-1]) begin
            return OP_HLT;
        end
        return opcode_e'(raw);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Combinational branch resolver. Returns taken_o=1 when the opcode is a
// branch whose condition holds for the current Z/N flags; non-branch opcodes
// always return 0.
//   opcode_i  decoded opcode
//   flag_z_i  datapath zero flag
//   flag_n_i  datapath negative flag
//   taken_o   branch taken
// -----------------------------------------------------------------------------
module branch_cond
    import cpu_pkg::*;
(
    input  opcode_e opcode_i,
    input  logic    flag_z_i,
    input  logic    flag_n_i,
    output logic    taken_o
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for opcodes the case does not list.
        taken_o = 1'b0;
        case (opcode_i)
            OP_BEQ:  taken_o = flag_z_i;
            OP_BNE:  taken_o = !flag_z_i;
            OP_BGT:  taken_o = !flag_z_i && !flag_n_i;
            OP_BGE:  taken_o = !flag_n_i;
            OP_BLT:  taken_o = flag_n_i;
            OP_BLE:  taken_o = flag_z_i || flag_n_i;
            OP_JMP:  taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle control FSM of the accumulator CPU. Holds PC, IR and state,
// fetches and decodes instructions and drives every datapath control input.
// All control outputs are Moore: decoded from the state and IR only.
//   clock_in           clock, rising edge
//   reset_n_in         asynchronous active-low reset
//   instr_in           instruction memory read data (one cycle after pc_out)
//   flag_Z_in/N_in     datapath status flags, sampled in EXEC
//   pc_out             instruction memory address
//   operand_out        IR operand field
//   sel_A_out          accumulator source (00 mem, 01 operand, 10 ALU)
//   sel_B_out          ALU B source (1 operand, 0 mem)
//   alu_op_out         0 add, 1 subtract
//   acc_wr_out         accumulator write enable
//   status_wr_out      status write enable
//   acc_reset_out      accumulator reset
//   status_reset_out   status register reset
//   mem_wr_out         data memory write strobe
//   halted_out         high while in HALT
// -----------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = cpu_pkg::DATA_WIDTH,
    parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH
) (
    input  logic                               clock_in,
    input  logic                               reset_n_in,
    input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instr_in,
    input  logic                               flag_Z_in,
    input  logic                               flag_N_in,
    output logic [DATA_WIDTH-1:0]              pc_out,
    output logic [DATA_WIDTH-1:0]              operand_out,
    output logic [1:0]                         sel_A_out,
    output logic                               sel_B_out,
    output logic                               alu_op_out,
    output logic                               acc_wr_out,
    output logic                               status_wr_out,
    output logic                               acc_reset_out,
    output logic                               status_reset_out,
    output logic                               mem_wr_out,
    output logic                               halted_out
);

    localparam int IW = OPCODE_WIDTH + DATA_WIDTH;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  pc_q, pc_d;
    logic [IW-1:0]          ir_q, ir_d;

    opcode_e                opcode;
    logic [DATA_WIDTH-1:0]  operand;
    logic                   branch_taken;

    assign opcode  = decode_opcode(ir_q[IW-1 -: OPCODE_WIDTH]);
    assign operand = ir_q[DATA_WIDTH-1:0];

    branch_cond u_branch_cond (
        .opcode_i (opcode),
        .flag_z_i (flag_Z_in),
        .flag_n_i (flag_N_in),
        .taken_o  (branch_taken)
    );

    // State, PC and IR registers.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, independent of order.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic, including PC/IR updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = instr_in;
                pc_d    = pc_q + DATA_WIDTH'(1);   // wraps to 0 at the top
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // branch_cond only fires for branch opcodes; a taken branch
                // replaces the PC+1 written during DECODE.
                if (branch_taken) begin
                    pc_d = operand;
                end
                case (opcode)
                    OP_HLT:                state_d = ST_HALT;
                    OP_LD, OP_ADD, OP_SUB: state_d = ST_MEMWB;
                    default:               state_d = ST_FETCH;
                endcase
            end
            ST_MEMWB:  state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // Moore output decode.
    always_comb begin
        sel_A_out        = SEL_A_MEM;
        sel_B_out        = SEL_B_MEM;
        alu_op_out       = ALU_ADD;
        acc_wr_out       = 1'b0;
        status_wr_out    = 1'b0;
        acc_reset_out    = 1'b0;
        status_reset_out = 1'b0;
        mem_wr_out       = 1'b0;
        halted_out       = 1'b0;
        case (state_q)
            ST_INIT: begin
                acc_reset_out    = 1'b1;
                status_reset_out = 1'b1;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        sel_A_out  = SEL_A_IMM;
                        acc_wr_out = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_B_out     = SEL_B_IMM;
                        alu_op_out    = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
                        sel_A_out     = SEL_A_ALU;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    OP_STO:  mem_wr_out = 1'b1;
                    default: ;
                endcase
            end
            ST_MEMWB: begin
                // The data memory read was addressed by operand_out during
                // EXEC, so its data is valid here.
                case (opcode)
                    OP_LD: begin
                        sel_A_out  = SEL_A_MEM;
                        acc_wr_out = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        sel_B_out     = SEL_B_MEM;
                        alu_op_out    = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                        sel_A_out     = SEL_A_ALU;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: halted_out = 1'b1;
            default: ;
        endcase
    end

    assign pc_out      = pc_q;
    assign operand_out = operand;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. A registered instruction memory model
// feeds instr_in; control outputs are packed into one vector and compared
// one cycle at a time against hand-computed values.
// Control vector bit order:
//   [9:8] sel_A [7] sel_B [6] alu_op [5] acc_wr [4] status_wr
//   [3] acc_reset [2] status_reset [1] mem_wr [0] halted
// -----------------------------------------------------------------------------
module tb_control_unit;
    import cpu_pkg::*;

    localparam logic [9:0] C_NONE  = 10'b00_0_0_0_0_0_0_0_0;
    localparam logic [9:0] C_RST   = 10'b00_0_0_0_0_1_1_0_0;
    localparam logic [9:0] C_LDI   = 10'b01_0_0_1_0_0_0_0_0;
    localparam logic [9:0] C_ADDI  = 10'b10_1_0_1_1_0_0_0_0;
    localparam logic [9:0] C_SUBI  = 10'b10_1_1_1_1_0_0_0_0;
    localparam logic [9:0] C_STO   = 10'b00_0_0_0_0_0_0_1_0;
    localparam logic [9:0] C_LD_M  = 10'b00_0_0_1_0_0_0_0_0;
    localparam logic [9:0] C_ADD_M = 10'b10_0_0_1_1_0_0_0_0;
    localparam logic [9:0] C_SUB_M = 10'b10_0_1_1_1_0_0_0_0;
    localparam logic [9:0] C_HALT  = 10'b00_0_0_0_0_0_0_0_1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr;
    logic        flag_z = 1'b0;
    logic        flag_n = 1'b0;
    logic [10:0] pc, operand;
    logic [1:0]  sel_a;
    logic        sel_b, alu_op, acc_wr, status_wr, acc_rst, status_rst, mem_wr, halted;
    logic [9:0]  ctrl;

    logic [15:0] imem [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data valid one cycle after pc_out.
    always @(posedge clk) instr <= imem[pc];

    control_unit dut (
        .clock_in         (clk),
        .reset_n_in       (rst_n),
        .instr_in         (instr),
        .flag_Z_in        (flag_z),
        .flag_N_in        (flag_n),
        .pc_out           (pc),
        .operand_out      (operand),
        .sel_A_out        (sel_a),
        .sel_B_out        (sel_b),
        .alu_op_out       (alu_op),
        .acc_wr_out       (acc_wr),
        .status_wr_out    (status_wr),
        .acc_reset_out    (acc_rst),
        .status_reset_out (status_rst),
        .mem_wr_out       (mem_wr),
        .halted_out       (halted)
    );

    assign ctrl = {sel_a, sel_b, alu_op, acc_wr, status_wr, acc_rst, status_rst, mem_wr, halted};

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then check PC and control vector.
    task automatic step_chk(input string tag, input logic [10:0] epc, input logic [9:0] ectrl);
        @(posedge clk);
        #1;
        check({tag, ".pc"}, {5'd0, pc}, {5'd0, epc});
        check({tag, ".ctrl"}, {6'd0, ctrl}, {6'd0, ectrl});
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
    endtask

    // Reset across one edge, check the reset state, release at the negedge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".rst_pc"}, {5'd0, pc}, 16'h0000);
        check({tag, ".rst_opd"}, {5'd0, operand}, 16'h0000);
        check({tag, ".rst_ctrl"}, {6'd0, ctrl}, {6'd0, C_RST});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [4:0] br_ops [7];
    logic [2:0] br_tab [7];   // bit k: taken for flag combo k (0:Z0N0 1:Z0N1 2:Z1N0)
    logic       exp_taken;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- LDI 5; ADDI 3; STO 20; HLT ----------------
        clear_imem();
        imem[0] = ins(OP_LDI, 11'd5);
        imem[1] = ins(OP_ADDI, 11'd3);
        imem[2] = ins(OP_STO, 11'd20);
        imem[3] = ins(OP_HLT, 11'd0);
        do_reset("prog");
        step_chk("prog.c1_fetch", 11'd0, C_NONE);
        step_chk("prog.c2_dec", 11'd0, C_NONE);
        step_chk("prog.c3_ldi", 11'd1, C_LDI);
        check("prog.c3_opd", {5'd0, operand}, 16'd5);
        step_chk("prog.c4", 11'd1, C_NONE);
        step_chk("prog.c5", 11'd1, C_NONE);
        step_chk("prog.c6_addi", 11'd2, C_ADDI);
        check("prog.c6_opd", {5'd0, operand}, 16'd3);
        step_chk("prog.c7", 11'd2, C_NONE);
        step_chk("prog.c8", 11'd2, C_NONE);
        step_chk("prog.c9_sto", 11'd3, C_STO);
        check("prog.c9_opd", {5'd0, operand}, 16'd20);
        step_chk("prog.c10", 11'd3, C_NONE);
        step_chk("prog.c11", 11'd3, C_NONE);
        step_chk("prog.c12_hlt_exec", 11'd4, C_NONE);
        for (int i = 0; i < 4; i++) step_chk("prog.halt", 11'd4, C_HALT);

        // ---------------- reset in EXEC of ADD ----------------
        clear_imem();
        imem[0] = ins(OP_ADD, 11'd7);
        do_reset("rmid");
        step_chk("rmid.fetch", 11'd0, C_NONE);
        step_chk("rmid.dec", 11'd0, C_NONE);
        step_chk("rmid.exec", 11'd1, C_NONE);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid.async_pc", {5'd0, pc}, 16'h0000);
        check("rmid.async_opd", {5'd0, operand}, 16'h0000);
        check("rmid.async_ctrl", {6'd0, ctrl}, {6'd0, C_RST});
        step_chk("rmid.held", 11'd0, C_RST);
        @(negedge clk);
        rst_n = 1'b1;
        step_chk("rmid.refetch", 11'd0, C_NONE);
        step_chk("rmid.redec", 11'd0, C_NONE);
        step_chk("rmid.reexec", 11'd1, C_NONE);
        check("rmid.reexec_opd", {5'd0, operand}, 16'd7);

        // ---------------- SUB / LD / ADD / SUBI ----------------
        clear_imem();
        imem[0] = ins(OP_SUB, 11'd7);
        imem[1] = ins(OP_LD, 11'd9);
        imem[2] = ins(OP_ADD, 11'd2);
        imem[3] = ins(OP_SUBI, 11'd1);
        do_reset("mem");
        step_chk("mem.sub_f", 11'd0, C_NONE);
        step_chk("mem.sub_d", 11'd0, C_NONE);
        step_chk("mem.sub_e", 11'd1, C_NONE);
        check("mem.sub_opd", {5'd0, operand}, 16'd7);
        step_chk("mem.sub_wb", 11'd1, C_SUB_M);
        step_chk("mem.ld_f", 11'd1, C_NONE);
        step_chk("mem.ld_d", 11'd1, C_NONE);
        step_chk("mem.ld_e", 11'd2, C_NONE);
        step_chk("mem.ld_wb", 11'd2, C_LD_M);
        step_chk("mem.add_f", 11'd2, C_NONE);
        step_chk("mem.add_d", 11'd2, C_NONE);
        step_chk("mem.add_e", 11'd3, C_NONE);
        step_chk("mem.add_wb", 11'd3, C_ADD_M);
        step_chk("mem.subi_f", 11'd3, C_NONE);
        step_chk("mem.subi_d", 11'd3, C_NONE);
        step_chk("mem.subi_e", 11'd4, C_SUBI);

        // ---------------- branches x flags ----------------
        br_ops[0] = OP_BEQ;  br_tab[0] = 3'b100;
        br_ops[1] = OP_BNE;  br_tab[1] = 3'b011;
        br_ops[2] = OP_BGT;  br_tab[2] = 3'b001;
        br_ops[3] = OP_BGE;  br_tab[3] = 3'b101;
        br_ops[4] = OP_BLT;  br_tab[4] = 3'b010;
        br_ops[5] = OP_BLE;  br_tab[5] = 3'b110;
        br_ops[6] = OP_JMP;  br_tab[6] = 3'b111;
        for (int b = 0; b < 7; b++) begin
            for (int f = 0; f < 3; f++) begin
                clear_imem();
                imem[0] = ins(br_ops[b], 11'h040);
                flag_z = (f == 2);
                flag_n = (f == 1);
                exp_taken = br_tab[b][f];
                do_reset($sformatf("br%0d_f%0d", b, f));
                repeat (3) @(posedge clk);
                #1;
                check($sformatf("br%0d_f%0d.exec_ctrl", b, f), {6'd0, ctrl}, {6'd0, C_NONE});
                step_chk($sformatf("br%0d_f%0d.next_fetch", b, f),
                         exp_taken ? 11'h040 : 11'h001, C_NONE);
            end
        end
        flag_z = 1'b0;
        flag_n = 1'b0;

        // ---------------- PC wrap: JMP 0x7FF; NOP at 0x7FF ----------------
        clear_imem();
        imem[0]     = ins(OP_JMP, 11'h7FF);
        imem[11'h7FF] = ins(OP_NOP, 11'd0);
        do_reset("wrap");
        repeat (3) @(posedge clk);
        step_chk("wrap.fetch_7ff", 11'h7FF, C_NONE);
        step_chk("wrap.dec_7ff", 11'h7FF, C_NONE);
        step_chk("wrap.nop_exec", 11'h000, C_NONE);
        step_chk("wrap.fetch_0", 11'h000, C_NONE);

        // ---------------- illegal opcode 10110 ----------------
        clear_imem();
        imem[0] = 16'b10110_000_0000_0011;
        do_reset("ill");
        step_chk("ill.fetch", 11'd0, C_NONE);
        step_chk("ill.dec", 11'd0, C_NONE);
        step_chk("ill.exec", 11'd1, C_NONE);
        step_chk("ill.halt", 11'd1, C_HALT);
        step_chk("ill.halt_stay", 11'd1, C_HALT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
